// File: rtl/trivium_sched.sv
// Byte-level scheduler around a Trivium keystream core: collects key/IV over the
// UART, warms the core up, then encrypts one received byte at a time into the TX FIFO.
//
// state  | meaning
// -------+-------------------------------------------------------------
// KEY    | collecting 10 key bytes, byte n -> core_key[8n+7:8n]
// IV     | collecting 10 IV bytes, same ordering
// LOAD   | single-cycle core_load pulse
// WARMUP | core stepped WARMUP_CYCLES times, keystream discarded
// READY  | waiting for a plaintext byte
// GEN    | 8 core steps, one keystream bit captured per step (LSB first)
// WRITE  | ciphertext presented to the FIFO, held while fifo_full
module trivium_sched #(
    parameter int WARMUP_CYCLES = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        core_ks_bit,
    output logic [79:0] core_key,
    output logic [79:0] core_iv,
    output logic        core_load,
    output logic        core_en,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        enc_done,
    output logic        ready,
    output logic        drop_err
);

    localparam int WARM_W_MIN = $clog2(WARMUP_CYCLES + 1);
    localparam int WARM_W     = (WARM_W_MIN > 11) ? WARM_W_MIN : 11;
    // Down-counter starts at N-1 and exits on zero, giving exactly N enabled cycles.
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

    localparam logic [2:0] ST_KEY    = 3'd0;
    localparam logic [2:0] ST_IV     = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_WARMUP = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;
    localparam logic [2:0] ST_GEN    = 3'd5;
    localparam logic [2:0] ST_WRITE  = 3'd6;

    logic [2:0]        state_q,    state_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [2:0]        gen_cnt_q,  gen_cnt_d;
    logic [79:0]       key_q,      key_d;
    logic [79:0]       iv_q,       iv_d;
    logic [7:0]        pt_q,       pt_d;
    logic [7:0]        ks_q,       ks_d;
    logic [7:0]        wr_data_q,  wr_data_d;
    logic              drop_q,     drop_d;

    logic busy;
    logic wr_fire;

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_WARMUP) ||
                     (state_q == ST_GEN)  || (state_q == ST_WRITE);
    assign wr_fire = (state_q == ST_WRITE) && !fifo_full;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        warm_cnt_d = warm_cnt_q;
        gen_cnt_d  = gen_cnt_q;
        key_d      = key_q;
        iv_d       = iv_q;
        pt_d       = pt_q;
        ks_d       = ks_q;
        wr_data_d  = wr_data_q;
        drop_d     = drop_q;

        if (rx_valid && busy) begin
            drop_d = 1'b1;
        end

        case (state_q)
            ST_KEY: begin
                if (rx_valid) begin
                    for (int n = 0; n < 10; n++) begin
                        if (byte_cnt_q == 4'(n)) begin
                            key_d[8*n +: 8] = rx_data;
                        end
                    end
                    if (byte_cnt_q == 4'd9) begin
                        byte_cnt_d = 4'd0;
                        state_d    = ST_IV;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            ST_IV: begin
                if (rx_valid) begin
                    for (int n = 0; n < 10; n++) begin
                        if (byte_cnt_q == 4'(n)) begin
                            iv_d[8*n +: 8] = rx_data;
                        end
                    end
                    if (byte_cnt_q == 4'd9) begin
                        byte_cnt_d = 4'd0;
                        state_d    = ST_LOAD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOAD: begin
                warm_cnt_d = WARM_LAST;
                state_d    = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (warm_cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    warm_cnt_d = warm_cnt_q - 1'b1;
                end
            end
            ST_READY: begin
                if (rx_valid) begin
                    pt_d      = rx_data;
                    gen_cnt_d = 3'd0;
                    state_d   = ST_GEN;
                end
            end
            ST_GEN: begin
                ks_d[gen_cnt_q] = core_ks_bit;
                gen_cnt_d       = gen_cnt_q + 3'd1;
                if (gen_cnt_q == 3'd7) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!fifo_full) begin
                    wr_data_d = pt_q ^ ks_q;
                    state_d   = ST_READY;
                end
            end
            default: begin
                state_d = ST_KEY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_KEY;
            byte_cnt_q <= '0;
            warm_cnt_q <= '0;
            gen_cnt_q  <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            pt_q       <= '0;
            ks_q       <= '0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            gen_cnt_q  <= gen_cnt_d;
            key_q      <= key_d;
            iv_q       <= iv_d;
            pt_q       <= pt_d;
            ks_q       <= ks_d;
            wr_data_q  <= wr_data_d;
            drop_q     <= drop_d;
        end
    end

    // Strobes are gated by rst so an abort never leaks a partial FIFO write.
    assign core_load    = !rst && (state_q == ST_LOAD);
    assign core_en      = !rst && ((state_q == ST_WARMUP) || (state_q == ST_GEN));
    assign fifo_wr_en   = !rst && wr_fire;
    assign enc_done     = !rst && wr_fire;
    assign ready        = !rst && (state_q == ST_READY);
    assign fifo_wr_data = fifo_wr_en ? (pt_q ^ ks_q) : wr_data_q;
    assign core_key     = key_q;
    assign core_iv      = iv_q;
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_trivium_sched.sv
// Self-checking bench for trivium_sched: timeline reference model checked every
// cycle, directed key/IV/encrypt/backpressure/overrun/reset cases, then random traffic.
module tb_trivium_sched;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        core_ks_bit;
    logic [79:0] core_key;
    logic [79:0] core_iv;
    logic        core_load;
    logic        core_en;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        enc_done;
    logic        ready;
    logic        drop_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trivium_sched #(.WARMUP_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .core_ks_bit (core_ks_bit),
        .core_key    (core_key),
        .core_iv     (core_iv),
        .core_load   (core_load),
        .core_en     (core_en),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .enc_done    (enc_done),
        .ready       (ready),
        .drop_err    (drop_err)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs just after the rising edge, then lets outputs settle.
    task automatic step(input logic v, input logic [7:0] d, input logic f,
                        input logic k, input logic r);
        @(posedge clk);
        #1;
        rst         = r;
        rx_valid    = v;
        rx_data     = d;
        fifo_full   = f;
        core_ks_bit = k;
        #1;
    endtask

    // Reference model: phases are derived from event timestamps (cycle of 20th
    // config byte, cycle a plaintext byte was accepted), not from a state register.
    int          cyc     = 0;
    bit          m_valid = 0;
    int          cfg_cnt;
    int          load_at;
    int          enc_t;
    logic [79:0] m_key, m_iv;
    logic [7:0]  m_pt, m_ks, m_last;
    logic        m_drop;

    initial begin
        forever begin
            logic       e_load, e_en, e_wr, e_ready;
            logic [7:0] e_data;
            @(negedge clk);
            e_load = 0; e_en = 0; e_wr = 0; e_ready = 0;
            e_data = m_last;
            if (!rst && m_valid) begin
                if (cfg_cnt < 20) begin
                end else if (cyc == load_at) begin
                    e_load = 1;
                end else if (cyc <= load_at + W) begin
                    e_en = 1;
                end else if (enc_t < 0) begin
                    e_ready = 1;
                end else if (cyc <= enc_t + 8) begin
                    e_en = 1;
                end else if (!fifo_full) begin
                    e_wr   = 1;
                    e_data = m_pt ^ m_ks;
                end
            end
            if (rst || m_valid) begin
                chk("core_load", 80'(core_load), 80'(e_load));
                chk("core_en", 80'(core_en), 80'(e_en));
                chk("fifo_wr_en", 80'(fifo_wr_en), 80'(e_wr));
                chk("enc_done", 80'(enc_done), 80'(e_wr));
                chk("ready", 80'(ready), 80'(e_ready));
            end
            if (m_valid) begin
                chk("fifo_wr_data", 80'(fifo_wr_data), 80'(e_data));
                chk("core_key", core_key, m_key);
                chk("core_iv", core_iv, m_iv);
                chk("drop_err", 80'(drop_err), 80'(m_drop));
            end
            if (rst) begin
                m_valid = 1; cfg_cnt = 0; load_at = -1; enc_t = -1;
                m_key = '0; m_iv = '0; m_pt = '0; m_ks = '0; m_last = '0; m_drop = 0;
            end else if (m_valid) begin
                if (cfg_cnt < 20) begin
                    if (rx_valid) begin
                        if (cfg_cnt < 10) m_key[8*cfg_cnt +: 8] = rx_data;
                        else              m_iv[8*(cfg_cnt-10) +: 8] = rx_data;
                        cfg_cnt++;
                        if (cfg_cnt == 20) load_at = cyc + 1;
                    end
                end else if (e_ready) begin
                    if (rx_valid) begin
                        m_pt  = rx_data;
                        enc_t = cyc;
                    end
                end else if (rx_valid) begin
                    m_drop = 1;
                end
                if (enc_t >= 0 && cyc > enc_t && cyc <= enc_t + 8)
                    m_ks[cyc - enc_t - 1] = core_ks_bit;
                if (e_wr) begin
                    m_last = e_data;
                    enc_t  = -1;
                end
            end
            cyc++;
        end
    end

    task automatic send_cfg();
        for (int i = 0; i < 20; i++) step(1, 8'(i), 0, 1'($urandom), 0);
    endtask

    task automatic do_load();
        int en_cnt;
        send_cfg();
        step(0, 0, 0, 1'($urandom), 0);
        chk("load_pulse", 80'(core_load), 80'(1));
        chk("load_no_en", 80'(core_en), 80'(0));
        en_cnt = 0;
        for (int j = 0; j < 10 && !ready; j++) begin
            step(0, 0, 0, 1'($urandom), 0);
            if (core_en) en_cnt++;
        end
        chk("warmup_len", 80'(en_cnt), 80'(W));
        chk("ready_after_warm", 80'(ready), 80'(1));
        chk("key_literal", core_key, 80'h09080706050403020100);
        chk("iv_literal", core_iv, 80'h131211100F0E0D0C0B0A);
    endtask

    task automatic encrypt(input logic [7:0] pt, input logic [7:0] ks, input int stall,
                           input int drop_at, input logic [7:0] ct);
        logic [7:0] ksv;
        ksv = ks;
        step(1, pt, 0, 1'($urandom), 0);
        chk("enc_ready", 80'(ready), 80'(1));
        for (int k = 0; k < 8; k++) begin
            step(k == drop_at, 8'h3C, 0, ksv[k], 0);
            chk("gen_en", 80'(core_en), 80'(1));
        end
        for (int s = 0; s < stall; s++) begin
            step(0, 0, 1, 1'($urandom), 0);
            chk("stall_no_wr", 80'(fifo_wr_en), 80'(0));
            chk("stall_no_en", 80'(core_en), 80'(0));
        end
        step(0, 0, 0, 1'($urandom), 0);
        chk("wr_en_lit", 80'(fifo_wr_en), 80'(1));
        chk("done_lit", 80'(enc_done), 80'(1));
        chk("ct_lit", 80'(fifo_wr_data), 80'(ct));
        step(0, 0, 0, 1'($urandom), 0);
        chk("single_write", 80'(fifo_wr_en), 80'(0));
        chk("ct_hold", 80'(fifo_wr_data), 80'(ct));
    endtask

    initial begin
        int wr_cnt;
        rst = 1; rx_valid = 0; rx_data = 0; fifo_full = 0; core_ks_bit = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("rst_ready", 80'(ready), 80'(0));
        chk("rst_key", core_key, 80'h0);
        chk("rst_drop", 80'(drop_err), 80'(0));

        do_load();
        encrypt(8'hA5, 8'h0D, 0, -1, 8'hA8);
        encrypt(8'h5A, 8'hFF, 5, -1, 8'hA5);
        encrypt(8'h11, 8'h00, 0, 3, 8'h11);
        chk("overrun_drop", 80'(drop_err), 80'(1));
        wr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1'($urandom), 0);
            if (fifo_wr_en) wr_cnt++;
        end
        chk("no_3c_write", 80'(wr_cnt), 80'(0));

        // Reset in warm-up cycle 2, then reload from scratch.
        send_cfg();
        step(0, 0, 0, 1'($urandom), 0);
        step(0, 0, 0, 1'($urandom), 0);
        step(0, 0, 0, 1'($urandom), 0);
        step(0, 0, 0, 1'($urandom), 1);
        chk("midwarm_en", 80'(core_en), 80'(0));
        chk("midwarm_wr", 80'(fifo_wr_en), 80'(0));
        step(0, 0, 0, 1'($urandom), 0);
        chk("midwarm_key", core_key, 80'h0);
        chk("midwarm_drop", 80'(drop_err), 80'(0));
        do_load();
        encrypt(8'hA5, 8'h0D, 0, -1, 8'hA8);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 1'($urandom), $urandom_range(0, 599) == 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trivium_sched.md
TRIVIUM_SCHED -- requirements
Module: trivium_sched

Interface
REQ-001 Parameter: WARMUP_CYCLES, 1152, number of core steps run after key/IV load before any keystream is used.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  system clock (100 MHz); all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- core_ks_bit  in  1  keystream bit from the Trivium core; valid in any cycle core_en=1.
- core_key  out  80  key to the core.
- core_iv  out  80  IV to the core.
- core_load  out  1  one-cycle pulse; core loads core_key/core_iv.
- core_en  out  1  advance the core one step this cycle.
- fifo_full  in  1  TX FIFO full.
- fifo_wr_en  out  1  write strobe to the TX FIFO.
- fifo_wr_data  out  8  ciphertext byte.
- enc_done  out  1  one-cycle pulse per completed byte (to UART receiver).
- ready  out  1  high only in state READY.
- drop_err  out  1  sticky flag: a received byte was discarded.

Function
REQ-003 States: KEY, IV, LOAD, WARMUP, READY, GEN, WRITE.
REQ-004 KEY: collects 10 rx_valid bytes; byte n (0..9) SHALL be written to core_key[8n+7:8n]; after the 10th byte, next state is IV.
REQ-005 IV: collects 10 bytes into core_iv in the same order; after the 10th byte, next state is LOAD.
REQ-006 LOAD: lasts exactly one cycle with core_load=1 and core_en=0; next state is WARMUP.
REQ-007 WARMUP: core_en=1 for exactly WARMUP_CYCLES consecutive cycles; keystream is ignored; next state is READY.
REQ-008 READY: ready=1; on rx_valid, rx_data is latched into plaintext register; next state is GEN.
REQ-009 GEN: core_en=1 for exactly 8 cycles; in GEN cycle k (0..7), core_ks_bit is captured into ks_byte[k]; next state is WRITE.
REQ-010 WRITE, fifo_full=0: for one cycle, fifo_wr_en=1, fifo_wr_data = plaintext XOR ks_byte, enc_done=1; next state is READY.
REQ-011 WRITE, fifo_full=1: stay in WRITE with fifo_wr_en=0, core_en=0, enc_done=0; the byte is never lost and never written twice.
REQ-012 Latency: rx_valid in READY at cycle T gives GEN during T+1..T+8 and the earliest fifo_wr_en at T+9.
REQ-013 core_en SHALL be 0 in KEY, IV, LOAD, READY and WRITE, so the keystream advances only in WARMUP and GEN.
REQ-014 rx_valid in LOAD, WARMUP, GEN or WRITE: the byte is discarded and drop_err is set to 1; it stays 1 until reset.
REQ-015 fifo_wr_data SHALL hold its last written value when fifo_wr_en=0.
REQ-016 Byte counters are 4 bits wide and clear on each KEY to IV and IV to LOAD transition; the warm-up counter is at least 11 bits and SHALL be sized from WARMUP_CYCLES.
REQ-017 No rekey path exists; only reset returns the block to KEY.

Reset
REQ-018 While rst=1 at a clock edge: state becomes KEY, and core_key, core_iv, ks_byte, plaintext, all counters, fifo_wr_data and drop_err are cleared to 0.
REQ-019 While rst=1, core_load, core_en, fifo_wr_en, enc_done and ready are all 0.
REQ-020 Reset in any state, including mid-WARMUP, mid-GEN and stalled WRITE, SHALL abort immediately with no partial FIFO write.

Verification (WARMUP_CYCLES=4 in simulation)
REQ-021 Reset: hold rst 2 cycles -> all outputs 0, ready=0; a subsequent byte lands in core_key[7:0].
REQ-022 Key/IV load: send bytes 0x00..0x13 -> core_key=0x09080706050403020100 and core_iv=0x13121110_0F0E0D0C0B0A; core_load pulses one cycle after the 20th byte; core_en is high exactly 4 cycles, then ready=1.
REQ-023 Encrypt: rx 0xA5 at T, core model drives ks bits 1,0,1,1,0,0,0,0 -> ks_byte=0x0D; fifo_wr_data=0xA8 with fifo_wr_en=1 and enc_done=1 at T+9 only.
REQ-024 Backpressure: fifo_full=1 for 5 cycles on WRITE entry -> no write and core_en=0 during those cycles; exactly one write of the correct byte in the first cycle with fifo_full=0.
REQ-025 Overrun: rx_valid 0x3C during GEN -> drop_err=1; the in-flight ciphertext is unchanged; 0x3C is never encrypted.
REQ-026 Reset mid-WARMUP (cycle 2) -> state KEY, core_key=0, no fifo_wr_en; a full re-load then behaves exactly as in REQ-022.
